sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the CPU's instruction and data SRAM ports (we/addr/wdata/rdata).
- Services one request every cycle: the read is always performed, and the write happens when `sram_we` is high.
- Read data is returned after a fixed, parameterised latency through a delay pipeline.
- Flags out-of-window accesses for the testbench and the trace checker.
- One instance is placed per port (instruction and data) in the SoC-lite wrapper.

Parameters:
- ADDR_BASE, 32'h1c00_0000: byte address that maps to word 0 of the array.
- DEPTH_LOG2, 14: log2 of the number of 32-bit words in the array.
- RD_LATENCY, 1: cycles from address sample to `sram_rdata`. Legal range is 1..4; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- sram_we  in  1  write enable for the word at `sram_addr`
- sram_addr  in  32  byte address; bits [1:0] are ignored
- sram_wdata  in  32  write data
- sram_rdata  out  32  read data, RD_LATENCY cycles after the address
- rd_valid  out  1  high when `sram_rdata` corresponds to a request sampled out of reset
- addr_err  out  1  sticky out-of-window flag
- err_addr  out  32  byte address of the first out-of-window access
- wr_count  out  32  number of committed writes, wraps modulo 2^32

Behaviour:
- Offset: off = sram_addr - ADDR_BASE, computed in 32 bits.
  - The access is in range iff off < 4 << DEPTH_LOG2, compared unsigned. Addresses below the base therefore wrap to large values and are out of range.
  - Word index = off[DEPTH_LOG2+1:2].
- Every rising edge out of reset samples the address. The array read is registered into pipeline stage 1.
  - Stages 2..RD_LATENCY are a shift register.
  - `sram_rdata` is the last stage.
- Write: on a rising edge with `sram_we`=1 and in range, mem[index] <= `sram_wdata` and `wr_count` increments by 1.
- Read-during-write to the same index in the same cycle is read-first: the pipeline receives the old word, and the new word is visible to the next cycle's read.
- Out-of-range request:
  - The write is dropped and `wr_count` is unchanged.
  - The pipeline carries 32'h0 for that request.
  - `addr_err` sets in the same edge.
  - If `addr_err` was 0, `err_addr` <= `sram_addr`; later errors do not overwrite it.
- rd_valid: a valid bit travels alongside each pipeline stage. A request sampled while out of reset enters as 1.
  - After reset deasserts, `rd_valid` rises RD_LATENCY cycles after the first sampling edge, then stays 1.
- Reset (asynchronous, whenever `resetn`=0), applied immediately without waiting for a clock edge:
  - `sram_rdata`=0, all pipeline data and valid bits =0, `rd_valid`=0.
  - `addr_err`=0, `err_addr`=0, `wr_count`=0.
- Memory array contents are not reset. They survive reset and are loaded only through writes or simulation init.
- Reset mid-operation: in-flight reads are discarded and never appear at `sram_rdata`. A write presented on the edge where reset is asserted is not committed.
- No backpressure or stall input: the CPU may change the address every cycle and each cycle gets its own response.
- With RD_LATENCY=1 the timing matches the classic synchronous SRAM the multicycle CPU expects: address in cycle n, data in cycle n+1.

Decomposition:
- Shared package `sram_pkg`:
  - `SRAM_ADDR_BASE_DEFAULT` (32'h1c00_0000)
  - `SRAM_MAX_RD_LATENCY` (4)
  - word type (32 bits)
  - `SRAM_ERR_RDATA` (32'h0)
- One sub-module, `sram_rd_pipe`: data plus valid delay line, parameterised by depth, with async active-low clear.
- The array, range check and error/statistics registers live in the top of `sram_responder`.

Test Plan:
- Reset release, RD_LATENCY=1, read 0x1c00_0000 on a zeroed array -> `rd_valid` low for cycle 0 and high from cycle 1; `sram_rdata`=0.
- Write 0x1234_5678 to 0x1c00_0010, then read the same address next cycle -> `sram_rdata`=0x1234_5678 one cycle later; `wr_count`=1.
- Same-cycle write 0xdead_beef and read at 0x1c00_0020, which holds 0x1111_1111 -> that read returns 0x1111_1111; a read in the following cycle returns 0xdead_beef.
- Write to 0x1bff_fffc, then read 0x1c01_0000 with DEPTH_LOG2=14:
  - both return 0 and the write is dropped;
  - `addr_err`=1, `err_addr`=0x1bff_fffc (not overwritten by the second error);
  - `wr_count` unchanged.
- RD_LATENCY=3, back-to-back reads of addresses A0..A3 holding 1,2,3,4 -> `sram_rdata` = 1,2,3,4 on cycles 3..6.
- RD_LATENCY=3, assert `resetn` low mid-burst with a write pending, then release -> `sram_rdata`/`rd_valid` go to 0 immediately; no stale data emerges; the pending write is absent; `rd_valid` rises 3 cycles after release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants, word type and range helper for the CPU-side SRAM responders.
// Pure declarations: no latency or flow control of its own.
package sram_pkg;

  localparam logic [31:0] SRAM_ADDR_BASE_DEFAULT = 32'h1c00_0000;
  localparam int          SRAM_MAX_RD_LATENCY    = 4;

  typedef logic [31:0] sram_word_t;

  localparam sram_word_t SRAM_ERR_RDATA = 32'h0;

  // 33-bit compare so a window of 2^32 bytes does not overflow the limit.
  function automatic logic sram_in_range(input logic [31:0] off, input int depth_log2);
    return {1'b0, off} < (33'd4 << depth_log2);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line with a valid bit per stage; DEPTH cycles input to output.
// No backpressure: shifts every cycle, async clear drops everything in flight.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_vld,
  input  sram_word_t in_dat,
  output logic       out_vld,
  output sram_word_t out_dat
);

  logic [DEPTH-1:0] vld_q;
  sram_word_t       dat_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Word-addressed SRAM model for one CPU port: read every cycle, optional write, error tracking.
// Read data after RD_LATENCY cycles; no backpressure, a new request is accepted every cycle.
module sram_responder
  import sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = SRAM_ADDR_BASE_DEFAULT,
  parameter int          DEPTH_LOG2 = 14,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        rd_valid,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (RD_LATENCY < 1 || RD_LATENCY > SRAM_MAX_RD_LATENCY) begin : g_bad_latency
    $error("sram_responder: RD_LATENCY must be 1..%0d", SRAM_MAX_RD_LATENCY);
  end

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_en;
  sram_word_t            rd_word;
  sram_word_t            mem [DEPTH];

  assign off      = sram_addr - ADDR_BASE;
  assign in_range = sram_in_range(off, DEPTH_LOG2);
  assign idx      = off[DEPTH_LOG2+1:2];
  // Gating with resetn keeps a write on the reset-assert edge out of the array.
  assign wr_en    = sram_we & in_range & resetn;
  assign rd_word  = in_range ? mem[idx] : SRAM_ERR_RDATA;

  // Array is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= sram_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_count <= '0;
      addr_err <= 1'b0;
      err_addr <= '0;
    end else begin
      if (wr_en) wr_count <= wr_count + 32'd1;
      if (!in_range) begin
        addr_err <= 1'b1;
        if (!addr_err) err_addr <= sram_addr;
      end
    end
  end

  sram_rd_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .in_vld  (1'b1),
    .in_dat  (rd_word),
    .out_vld (rd_valid),
    .out_dat (sram_rdata)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Directed checks of sram_responder at read latencies 1 and 3.
module tb_sram_responder;
  import sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn1, we1, rd_valid1, addr_err1;
  logic [31:0] addr1, wdata1, rdata1, err_addr1, wr_count1;
  logic        rstn3, we3, rd_valid3, addr_err3;
  logic [31:0] addr3, wdata3, rdata3, err_addr3, wr_count3;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] A0 = 32'h1c00_0100;

  sram_responder #(.ADDR_BASE(32'h1c00_0000), .DEPTH_LOG2(14), .RD_LATENCY(1)) u1 (
    .clk(clk), .resetn(rstn1), .sram_we(we1), .sram_addr(addr1), .sram_wdata(wdata1),
    .sram_rdata(rdata1), .rd_valid(rd_valid1), .addr_err(addr_err1),
    .err_addr(err_addr1), .wr_count(wr_count1)
  );

  sram_responder #(.ADDR_BASE(32'h1c00_0000), .DEPTH_LOG2(14), .RD_LATENCY(3)) u3 (
    .clk(clk), .resetn(rstn3), .sram_we(we3), .sram_addr(addr3), .sram_wdata(wdata3),
    .sram_rdata(rdata3), .rd_valid(rd_valid3), .addr_err(addr_err3),
    .err_addr(err_addr3), .wr_count(wr_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge sample, return at the next falling edge.
  task automatic cyc1(input logic we, input logic [31:0] a, input logic [31:0] d);
    we1 = we; addr1 = a; wdata1 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc3(input logic we, input logic [31:0] a, input logic [31:0] d);
    we3 = we; addr3 = a; wdata3 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    rstn3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
    for (int i = 0; i < (1 << 14); i++) begin
      u1.mem[i] = '0;
      u3.mem[i] = '0;
    end
    repeat (2) @(negedge clk);

    check("rst rdata",    rdata1,    32'h0);
    check("rst rd_valid", {31'b0, rd_valid1}, 32'h0);
    check("rst addr_err", {31'b0, addr_err1}, 32'h0);
    check("rst err_addr", err_addr1, 32'h0);
    check("rst wr_count", wr_count1, 32'h0);

    // Latency 1: valid low in cycle 0, high from cycle 1.
    rstn1 = 1'b1;
    addr1 = 32'h1c00_0000;
    #1;
    check("l1 valid c0", {31'b0, rd_valid1}, 32'h0);
    @(negedge clk);
    cyc1(1'b0, 32'h1c00_0000, 32'h0);
    check("l1 valid c1", {31'b0, rd_valid1}, 32'h1);
    check("l1 rdata zero", rdata1, 32'h0);

    cyc1(1'b1, 32'h1c00_0010, 32'h1234_5678);
    check("wr_count 1", wr_count1, 32'h1);
    cyc1(1'b0, 32'h1c00_0010, 32'h0);
    check("readback", rdata1, 32'h1234_5678);

    // Read-first on same-cycle write.
    cyc1(1'b1, 32'h1c00_0020, 32'h1111_1111);
    cyc1(1'b1, 32'h1c00_0020, 32'hdead_beef);
    check("rdw old word", rdata1, 32'h1111_1111);
    check("wr_count 3", wr_count1, 32'h3);
    cyc1(1'b0, 32'h1c00_0020, 32'h0);
    check("rdw new word", rdata1, 32'hdead_beef);

    // Below-base write wraps to offset 0xffff_fffc: dropped, flagged.
    cyc1(1'b1, 32'h1bff_fffc, 32'haaaa_5555);
    check("oor lo rdata",  rdata1, 32'h0);
    check("oor lo err",    {31'b0, addr_err1}, 32'h1);
    check("oor lo eaddr",  err_addr1, 32'h1bff_fffc);
    check("oor lo wr_cnt", wr_count1, 32'h3);
    cyc1(1'b0, 32'h1c01_0000, 32'h0);
    check("oor hi rdata",  rdata1, 32'h0);
    check("oor hi eaddr",  err_addr1, 32'h1bff_fffc);
    // Top word of the window aliases the dropped write's index bits.
    cyc1(1'b0, 32'h1c00_fffc, 32'h0);
    check("top word rdata", rdata1, 32'h0);
    check("top word err",   {31'b0, addr_err1}, 32'h1);
    check("wr_count kept",  wr_count1, 32'h3);

    // Latency 3: preload A0..A3 with 1..4.
    rstn3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc3(1'b1, A0 + 32'(4 * k), 32'(k + 1));
      if (k == 0) check("l3 valid c0", {31'b0, rd_valid3}, 32'h0);
      if (k == 1) check("l3 valid c1", {31'b0, rd_valid3}, 32'h0);
      if (k == 2) check("l3 valid c2", {31'b0, rd_valid3}, 32'h1);
    end
    check("l3 wr_count", wr_count3, 32'h4);

    for (int k = 0; k < 6; k++) begin
      cyc3(1'b0, (k < 4) ? A0 + 32'(4 * k) : A0, 32'h0);
      if (k >= 2) check($sformatf("l3 burst %0d", k - 2), rdata3, 32'(k - 1));
    end

    // Reset mid-burst with a write to A0 presented on the reset edge.
    cyc3(1'b0, A0 + 32'd4, 32'h0);
    cyc3(1'b0, A0 + 32'd8, 32'h0);
    check("pre rst rdata", rdata3, 32'h1);
    we3 = 1'b1; addr3 = A0; wdata3 = 32'h0000_0099;
    rstn3 = 1'b0;
    #1;
    check("async rdata",    rdata3, 32'h0);
    check("async rd_valid", {31'b0, rd_valid3}, 32'h0);
    check("async wr_count", wr_count3, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc3(1'b0, A0, 32'h0);
      check($sformatf("post rst valid %0d", k), {31'b0, rd_valid3}, (k == 2) ? 32'h1 : 32'h0);
      check($sformatf("post rst rdata %0d", k), rdata3, (k == 2) ? 32'h1 : 32'h0);
    end
    check("post rst wr_count", wr_count3, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
